// File: rtl/att_lookup_sequencer_pkg.sv
// Shared types and helpers for the address translation table reader and its mask walkers.
package att_lookup_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2,
    ST_EMIT  = 2'd3
  } att_state_t;

  localparam int ATT_CLAUSE_COUNT   = 20;
  localparam int ATT_LIT_ADDR_WIDTH = 12;
  localparam int ATT_CT_ADDR_WIDTH  = 11;
  localparam int ATT_ENTRY_WIDTH    = ATT_CT_ADDR_WIDTH + ATT_CLAUSE_COUNT;

  typedef logic [ATT_ENTRY_WIDTH-1:0] att_entry_t;

  // Slot index width; a single-slot mask still needs a one-bit index.
  function automatic int att_slot_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Table entries hold the mask in the low bits and the clause base address above it.
  function automatic logic [ATT_CLAUSE_COUNT-1:0] att_entry_mask(input att_entry_t e);
    return e[ATT_CLAUSE_COUNT-1:0];
  endfunction

  function automatic logic [ATT_CT_ADDR_WIDTH-1:0] att_entry_addr(input att_entry_t e);
    return e[ATT_ENTRY_WIDTH-1:ATT_CLAUSE_COUNT];
  endfunction

  function automatic att_entry_t att_pack_entry(input logic [ATT_CT_ADDR_WIDTH-1:0] addr,
                                                input logic [ATT_CLAUSE_COUNT-1:0] mask);
    return {addr, mask};
  endfunction

endpackage

// File: rtl/att_lookup_sequencer_lowest.sv
// Combinational priority encoder: index of the lowest set bit, plus an any-set flag.
module att_lowest_set_index #(
  parameter int WIDTH = 20,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  always_comb begin
    index_o = '0;
    any_o   = |mask_i;
    // Scan downward so the lowest set bit is the last to overwrite the index.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/att_lookup_sequencer.sv
// Reads one table entry per literal request and walks its clause mask, lowest slot first.
module att_lookup_sequencer
  import att_lookup_sequencer_pkg::*;
#(
  parameter int  CLAUSE_COUNT               = ATT_CLAUSE_COUNT,
  parameter int  LITERAL_ADDRESS_WIDTH      = ATT_LIT_ADDR_WIDTH,
  parameter int  CLAUSE_TABLE_ADDRESS_WIDTH = ATT_CT_ADDR_WIDTH,
  localparam int SLOT_WIDTH                 = att_slot_width(CLAUSE_COUNT)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  lit_valid_i,
  output logic                                  lit_ready_o,
  input  logic [LITERAL_ADDRESS_WIDTH-2:0]      lit_addr_i,
  output logic [LITERAL_ADDRESS_WIDTH-2:0]      att_rd_addr_o,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i,
  input  logic [CLAUSE_COUNT-1:0]               att_mask_i,
  output logic                                  clause_valid_o,
  input  logic                                  clause_ready_i,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] clause_addr_o,
  output logic [SLOT_WIDTH-1:0]                 clause_slot_o,
  output logic                                  done_o
);

  att_state_t                            state_q, state_d;
  logic [LITERAL_ADDRESS_WIDTH-2:0]      rd_addr_q, rd_addr_d;
  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [CLAUSE_COUNT-1:0]               mask_q, mask_d;
  logic                                  done_q, done_d;

  logic [SLOT_WIDTH-1:0]   low_slot;
  logic                    mask_any;
  logic [CLAUSE_COUNT-1:0] mask_rest;
  logic                    emit_active;
  logic                    last_beat;

  att_lowest_set_index #(
    .WIDTH (CLAUSE_COUNT),
    .IDX_W (SLOT_WIDTH)
  ) u_lowest (
    .mask_i  (mask_q),
    .index_o (low_slot),
    .any_o   (mask_any)
  );

  // Clearing the lowest set bit is the classic m & (m - 1).
  assign mask_rest   = mask_q & (mask_q - CLAUSE_COUNT'(1));
  assign emit_active = (state_q == ST_EMIT) && mask_any;
  assign last_beat   = emit_active && clause_ready_i && (mask_rest == '0);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    base_d    = base_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lit_valid_i) begin
          rd_addr_d = lit_addr_i;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        base_d = att_addr_i;
        mask_d = att_mask_i;
        if (att_mask_i != '0) begin
          state_d = ST_EMIT;
        end else begin
          // Empty entry: nothing to emit, completion is flagged next cycle.
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (clause_ready_i) begin
          mask_d = mask_rest;
          if (mask_rest == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      base_q    <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
    end
  end

  assign lit_ready_o    = (state_q == ST_IDLE);
  assign att_rd_addr_o  = rd_addr_q;
  assign clause_valid_o = emit_active;
  assign clause_addr_o  = emit_active ? base_q : '0;
  assign clause_slot_o  = emit_active ? low_slot : '0;
  assign done_o         = done_q | last_beat;

endmodule

// File: tb/tb_att_lookup_sequencer.sv
// Directed bench: a registered-read table model feeds the sequencer; outputs checked every cycle.
module tb_att_lookup_sequencer;
  import att_lookup_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lit_valid_i;
  logic        lit_ready_o;
  logic [10:0] lit_addr_i;
  logic [10:0] att_rd_addr_o;
  logic [10:0] att_addr_i;
  logic [19:0] att_mask_i;
  logic        clause_valid_o;
  logic        clause_ready_i;
  logic [10:0] clause_addr_o;
  logic [4:0]  clause_slot_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  att_entry_t mem [0:2047];

  att_lookup_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lit_valid_i    (lit_valid_i),
    .lit_ready_o    (lit_ready_o),
    .lit_addr_i     (lit_addr_i),
    .att_rd_addr_o  (att_rd_addr_o),
    .att_addr_i     (att_addr_i),
    .att_mask_i     (att_mask_i),
    .clause_valid_o (clause_valid_o),
    .clause_ready_i (clause_ready_i),
    .clause_addr_o  (clause_addr_o),
    .clause_slot_o  (clause_slot_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Table with one-cycle registered read.
  always @(posedge clk_i) begin
    att_addr_i <= att_entry_addr(mem[att_rd_addr_o]);
    att_mask_i <= att_entry_mask(mem[att_rd_addr_o]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [10:0] a,
                         input logic [4:0] s, input logic d, input logic r);
    chk({tag, ".valid"}, 32'(clause_valid_o), 32'(v));
    chk({tag, ".addr"},  32'(clause_addr_o),  32'(a));
    chk({tag, ".slot"},  32'(clause_slot_o),  32'(s));
    chk({tag, ".done"},  32'(done_o),         32'(d));
    chk({tag, ".ready"}, 32'(lit_ready_o),    32'(r));
    $display("cycle %s: valid=%0d addr=%0h slot=%0d done=%0d ready=%0d rd_addr=%0h",
             tag, clause_valid_o, clause_addr_o, clause_slot_o, done_o, lit_ready_o, att_rd_addr_o);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look();
    @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h005] = att_pack_entry(11'h123, 20'h00011);
    mem[11'h7FF] = att_pack_entry(11'h000, 20'h00000);
    mem[11'h010] = att_pack_entry(11'h0AA, 20'h80001);
    mem[11'h020] = att_pack_entry(11'h3FF, 20'hFFFFF);
    mem[11'h030] = att_pack_entry(11'h055, 20'h0001F);
    mem[11'h031] = att_pack_entry(11'h111, 20'h00006);
    mem[11'h040] = att_pack_entry(11'h200, 20'h00008);
    mem[11'h041] = att_pack_entry(11'h201, 20'h00100);

    rst_i = 1'b1; lit_valid_i = 1'b0; lit_addr_i = '0; clause_ready_i = 1'b1;
    next_cycle(); next_cycle();
    rst_i = 1'b0;
    look();
    exp_out("reset", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    chk("reset.rd_addr", 32'(att_rd_addr_o), 32'h0);

    // Two-beat lookup
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h005; look();
    exp_out("t1.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look();
    exp_out("t1.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    chk("t1.rd_addr", 32'(att_rd_addr_o), 32'h005);
    next_cycle(); look(); exp_out("t1.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t1.c3", 1'b1, 11'h123, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t1.c4", 1'b1, 11'h123, 5'd4, 1'b1, 1'b0);
    next_cycle(); look(); exp_out("t1.c5", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);

    // Empty mask
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h7FF; look();
    exp_out("t2.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look();
    exp_out("t2.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    chk("t2.rd_addr", 32'(att_rd_addr_o), 32'h7FF);
    next_cycle(); look(); exp_out("t2.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t2.c3", 1'b0, 11'h0, 5'd0, 1'b1, 1'b1);
    next_cycle(); look(); exp_out("t2.c4", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);

    // Backpressure at slot 0, then slot 19
    clause_ready_i = 1'b0;
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h010; look();
    exp_out("t3.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look(); exp_out("t3.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t3.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); look(); exp_out($sformatf("t3.hold%0d", i), 1'b1, 11'h0AA, 5'd0, 1'b0, 1'b0);
    end
    next_cycle(); clause_ready_i = 1'b1; look();
    exp_out("t3.beat0", 1'b1, 11'h0AA, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t3.beat1", 1'b1, 11'h0AA, 5'd19, 1'b1, 1'b0);
    next_cycle(); look(); exp_out("t3.end", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);

    // Full mask
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h020; look();
    exp_out("t4.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look(); exp_out("t4.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t4.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      next_cycle(); look();
      exp_out($sformatf("t4.beat%0d", i), 1'b1, 11'h3FF, 5'(i), (i == 19), 1'b0);
    end
    next_cycle(); look(); exp_out("t4.end", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);

    // Reset during EMIT after two of five beats
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h030; look();
    exp_out("t5.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look(); exp_out("t5.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.beat0", 1'b1, 11'h055, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.beat1", 1'b1, 11'h055, 5'd1, 1'b0, 1'b0);
    next_cycle(); rst_i = 1'b1; look();
    exp_out("t5.rst", 1'b1, 11'h055, 5'd2, 1'b0, 1'b0);
    next_cycle(); rst_i = 1'b0; look();
    exp_out("t5.after", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    chk("t5.rd_addr", 32'(att_rd_addr_o), 32'h0);
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h031; look();
    exp_out("t5.r0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_valid_i = 1'b0; look(); exp_out("t5.r1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.r2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.r3", 1'b1, 11'h111, 5'd1, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t5.r4", 1'b1, 11'h111, 5'd2, 1'b1, 1'b0);
    next_cycle(); look(); exp_out("t5.r5", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);

    // Valid held high across two requests
    next_cycle(); lit_valid_i = 1'b1; lit_addr_i = 11'h040; look();
    exp_out("t6.c0", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    next_cycle(); lit_addr_i = 11'h041; look();
    exp_out("t6.c1", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    chk("t6.c1.rd_addr", 32'(att_rd_addr_o), 32'h040);
    next_cycle(); look(); exp_out("t6.c2", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    chk("t6.c2.rd_addr", 32'(att_rd_addr_o), 32'h040);
    next_cycle(); look(); exp_out("t6.c3", 1'b1, 11'h200, 5'd3, 1'b1, 1'b0);
    chk("t6.c3.rd_addr", 32'(att_rd_addr_o), 32'h040);
    next_cycle(); look(); exp_out("t6.c4", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    chk("t6.c4.rd_addr", 32'(att_rd_addr_o), 32'h040);
    next_cycle(); lit_valid_i = 1'b0; look();
    exp_out("t6.c5", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    chk("t6.c5.rd_addr", 32'(att_rd_addr_o), 32'h041);
    next_cycle(); look(); exp_out("t6.c6", 1'b0, 11'h0, 5'd0, 1'b0, 1'b0);
    next_cycle(); look(); exp_out("t6.c7", 1'b1, 11'h201, 5'd8, 1'b1, 1'b0);
    next_cycle(); look(); exp_out("t6.c8", 1'b0, 11'h0, 5'd0, 1'b0, 1'b1);
    chk("t6.c8.rd_addr", 32'(att_rd_addr_o), 32'h041);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/att_lookup_sequencer.md
Name: att_lookup_sequencer

Overview:
- Runtime reader for the address translation table.
- Accepts a literal lookup request over a valid/ready handshake and drives the table read address.
- Captures the table output after the table's one-cycle registered read latency: clause table base address plus the CLAUSE_COUNT-bit mask.
- Emits one clause reference per set mask bit, lowest bit first, to the downstream clause evaluator. Sits between the flip/selection logic and the clause table.

Parameters:
- CLAUSE_COUNT, 20, mask width; number of clause slots per table entry.
- LITERAL_ADDRESS_WIDTH, 12, literal address width. The runtime read address is LITERAL_ADDRESS_WIDTH-1 bits.
- CLAUSE_TABLE_ADDRESS_WIDTH, 11, clause table base address width.
- SLOT_WIDTH, $clog2(CLAUSE_COUNT), slot index width (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- lit_valid_i  in  1  lookup request valid.
- lit_ready_o  out  1  request accepted when valid & ready.
- lit_addr_i  in  LITERAL_ADDRESS_WIDTH-1  literal to look up.
- att_rd_addr_o  out  LITERAL_ADDRESS_WIDTH-1  table read address, registered.
- att_addr_i  in  CLAUSE_TABLE_ADDRESS_WIDTH  table output, address field.
- att_mask_i  in  CLAUSE_COUNT  table output, mask field.
- clause_valid_o  out  1  clause reference valid.
- clause_ready_i  in  1  downstream accepts the reference.
- clause_addr_o  out  CLAUSE_TABLE_ADDRESS_WIDTH  captured base address.
- clause_slot_o  out  SLOT_WIDTH  index of the mask bit being emitted.
- done_o  out  1  one-cycle pulse when a lookup completes.

Behaviour:
- Reset (rst_i high at a clk_i edge), effective from the next cycle:
  - state=IDLE.
  - All outputs and internal registers are 0, except lit_ready_o=1.
- Reset mid-operation aborts the lookup. No done_o pulse. Any pending clause is dropped.
- States:
  - IDLE: lit_ready_o=1. On lit_valid_i, register lit_addr_i into att_rd_addr_o and go to READ.
  - READ: one cycle. The table samples att_rd_addr_o at the closing edge. Go to LATCH.
  - LATCH: att_addr_i/att_mask_i are valid this cycle. Register them into base_q/mask_q.
    - mask nonzero: go to EMIT.
    - mask zero: pulse done_o in the following cycle and go to IDLE.
  - EMIT: clause_valid_o=1, clause_addr_o=base_q, clause_slot_o=index of the lowest set bit of mask_q.
    - On clause_ready_i, clear that bit.
    - If it was the last set bit: done_o=1 in the same cycle as the final handshake, next state IDLE.
- lit_ready_o=0 in all states except IDLE. There is no request pipelining.
- Minimum turnaround: request edge to first clause_valid_o is 3 cycles. The empty-mask lookup completes in 3 cycles.
- Outputs are stable while clause_valid_o=1 and clause_ready_i=0. Backpressure may last indefinitely.
- One emitted clause per cycle under continuous clause_ready_i. N set bits take N cycles in EMIT.
- Priority encoder: lowest index wins. Bit CLAUSE_COUNT-1 alone yields slot CLAUSE_COUNT-1.
- att_rd_addr_o holds its last value outside IDLE acceptance. It is 0 after reset.
- clause_addr_o and clause_slot_o are 0 when not in EMIT.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/READ/LATCH/EMIT);
  - SLOT_WIDTH derivation function;
  - table field split helper (mask = low CLAUSE_COUNT bits, address = upper bits).
- One sub-module: att_lowest_set_index. Combinational, CLAUSE_COUNT-in, outputs index plus any-set flag. Reused by other mask walkers.

Test Plan:
- Reset, then request lit 0x05 with table entry {addr=0x123, mask=0x00011}, clause_ready_i=1:
  - two clause beats (0x123,slot 0), (0x123,slot 4) at cycles 3 and 4;
  - done_o with the second beat;
  - lit_ready_o back high at cycle 5.
- Empty mask: lit 0x7FF, entry {0x000, 0x00000} -> no clause_valid_o; done_o pulse at cycle 3; back in IDLE.
- Backpressure: mask 0x80001, clause_ready_i low 4 cycles at slot 0 -> outputs held constant; then slot 0, slot 19 emitted; done_o once.
- Full mask 0xFFFFF with ready=1 -> 20 consecutive beats, slots 0..19 in order; done_o on the 20th.
- rst_i asserted during EMIT after 2 of 5 beats -> next cycle clause_valid_o=0, lit_ready_o=1, no done_o. A new request then runs normally.
- lit_valid_i held high across back-to-back requests -> second request accepted only after the IDLE return. att_rd_addr_o changes only at acceptance edges.
